sc_run_ctrl: RTL

Run-control sequencer for the single-cycle CPU (`sc_computer`). It owns the CPU's reset release and its clock-enable, so a board or bench can run, halt, single-step and stop on a PC breakpoint. It also counts executed instructions. It sits between the board key/switch inputs and `sc_computer`, and is clocked by the same `clock` as the CPU.

---
 rtl/sc_pkg.sv | 13 +
 rtl/sc_run_ctrl_if.sv | 28 ++
 rtl/sc_edge_det.sv | 17 +
 rtl/sc_run_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared constants for the single-cycle CPU run-control block.
package sc_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        HALT = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } state_t;

endpackage

// File: rtl/sc_run_ctrl_if.sv
// sc_run_ctrl_if: board/CPU-facing signal bundle of the run-control sequencer.
// master = board/CPU side, slave = sc_run_ctrl.
interface sc_run_ctrl_if;
    import sc_pkg::*;

    logic              run_req;
    logic              step_req;
    logic              halt_req;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] bp_addr;
    logic              bp_valid;
    logic              cpu_resetn;
    logic              cpu_en;
    logic              halted;
    logic              bp_hit_flag;
    logic [1:0]        state;
    logic [WORD_W-1:0] inst_count;

    modport master (
        output run_req, step_req, halt_req, pc, bp_addr, bp_valid,
        input  cpu_resetn, cpu_en, halted, bp_hit_flag, state, inst_count
    );

    modport slave (
        input  run_req, step_req, halt_req, pc, bp_addr, bp_valid,
        output cpu_resetn, cpu_en, halted, bp_hit_flag, state, inst_count
    );
endinterface

// File: rtl/sc_edge_det.sv
// sc_edge_det: rising-edge detector for a level request input.
module sc_edge_det (
    input  logic clock,
    input  logic resetn,
    input  logic din,
    output logic rise
);
    logic prev;

    // Previous-value register for the request level.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) prev <= 1'b0;
        else         prev <= din;
    end

    assign rise = din & ~prev;
endmodule

// File: rtl/sc_run_ctrl.sv
// sc_run_ctrl: run/halt/step/breakpoint sequencer for sc_computer.
// Optional feature macro: SC_RUN_CTRL_BP_EN enables the PC breakpoint
// comparator, the resume skip and the sticky bp_hit_flag.
module sc_run_ctrl
    import sc_pkg::*;
#(
    parameter int RST_CYCLES = 4
) (
    input  logic           clock,
    input  logic           resetn,
    sc_run_ctrl_if.slave   bus
);
    localparam logic [7:0] HOLD_LAST = 8'(RST_CYCLES - 1);

    state_t            st;
    logic [7:0]        hold_cnt;
    logic              skip;
    logic              bp_hit;
    logic              cpu_rel;
    logic              halted_q;
    logic [WORD_W-1:0] icount;

    // Request edges: bit 0 run, bit 1 step, bit 2 halt.
    logic [2:0] req_lvl;
    logic [2:0] req_rise;
    assign req_lvl = {bus.halt_req, bus.step_req, bus.run_req};

    for (genvar i = 0; i < 3; i++) begin : g_edge
        sc_edge_det u_det (
            .clock  (clock),
            .resetn (resetn),
            .din    (req_lvl[i]),
            .rise   (req_rise[i])
        );
    end

    logic run_e, step_e, halt_e;
    assign run_e  = req_rise[0];
    assign step_e = req_rise[1];
    assign halt_e = req_rise[2];

    // Word-address compare; the low two address bits never matter.
    logic bp_match;
`ifdef SC_RUN_CTRL_BP_EN
    assign bp_match = bus.bp_valid & (((bus.pc ^ bus.bp_addr) & ~32'h3) == '0);
`else
    assign bp_match = 1'b0;
`endif

    // Stop before the breakpoint instruction executes, unless just resumed.
    logic bp_stop;
    logic cpu_en_c;
    assign bp_stop  = (st == RUN) & bp_match & ~skip;
    assign cpu_en_c = (st == STEP) | ((st == RUN) & ~bp_stop);

    // Sequencer FSM with hold counter, skip flag and retired-instruction count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            st       <= HOLD;
            hold_cnt <= '0;
            skip     <= 1'b0;
            bp_hit   <= 1'b0;
            cpu_rel  <= 1'b0;
            halted_q <= 1'b0;
            icount   <= '0;
        end else begin
            if (cpu_en_c) icount <= icount + 32'd1;
            case (st)
                HOLD: begin
                    icount <= '0;
                    if (hold_cnt == HOLD_LAST) begin
                        st       <= HALT;
                        hold_cnt <= '0;
                        cpu_rel  <= 1'b1;
                        halted_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                HALT: begin
                    if (halt_e) begin
                        st <= HALT;
                    end else if (step_e) begin
                        st       <= STEP;
                        halted_q <= 1'b0;
                        bp_hit   <= 1'b0;
                    end else if (run_e) begin
                        st       <= RUN;
                        halted_q <= 1'b0;
                        bp_hit   <= 1'b0;
                        skip     <= 1'b1;
                    end
                end
                RUN: begin
                    skip <= 1'b0;
                    if (halt_e || bp_stop) begin
                        st       <= HALT;
                        halted_q <= 1'b1;
                    end
                    if (bp_stop) bp_hit <= 1'b1;
                end
                default: begin
                    st       <= HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cpu_en      = cpu_en_c;
    assign bus.cpu_resetn  = cpu_rel;
    assign bus.halted      = halted_q;
    assign bus.bp_hit_flag = bp_hit;
    assign bus.state       = st;
    assign bus.inst_count  = icount;
endmodule
